// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Passes non-memory results straight through
// to mem_wb and serialises LOAD/STORE accesses onto the 8-bit external bus as
// little-endian byte transfers, holding the pipeline stalled until the access
// has completed. Any memory opcode that is not STORE is handled as a load.
module mem_access #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        aluop_i,
   input  logic [2:0]        alufunct3_i,
   input  logic              me_i,
   input  logic [ADDR_W-1:0] maddr_i,
   input  logic              wreg_i,
   input  logic [4:0]        wd_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              gnt_i,
   output logic              req_o,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   output logic              mem_wr,
   input  logic [7:0]        mem_din,
   output logic              stall_o,
   output logic              wreg_o,
   output logic [4:0]        wd_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              wreg_f,
   output logic [4:0]        wd_f,
   output logic [DATA_W-1:0] wdata_f
);

   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_GNT,
      XFER,
      DRAIN,
      DONE
   } state_t;

   state_t            state;
   logic [1:0]        idx;
   logic [DATA_W-1:0] load_buf;

   logic              is_store;
   logic              illegal_size;
   logic [1:0]        last_idx;
   logic [1:0]        prev_idx;
   logic [1:0]        next_idx;
   logic [DATA_W-1:0] load_ext;

   // Decode access size/kind and the neighbouring byte indices of the transfer
   always_comb begin
      is_store     = (aluop_i == OP_STORE);
      illegal_size = (alufunct3_i[1:0] == 2'b11);
      case (alufunct3_i[1:0])
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
      prev_idx = idx - 2'd1;
      next_idx = idx + 2'd1;
   end

   // Byte-serial bus sequencer; read bytes arrive one cycle after their address
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= 2'd0;
         req_o    <= 1'b0;
         mem_wr   <= 1'b0;
         mem_a    <= '0;
         mem_dout <= 8'd0;
         load_buf <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (me_i) begin
                  load_buf <= '0;
                  if (illegal_size) begin
                     state <= DONE;
                  end else begin
                     state <= WAIT_GNT;
                     req_o <= 1'b1;
                  end
               end
            end
            WAIT_GNT: begin
               if (gnt_i) begin
                  state    <= XFER;
                  idx      <= 2'd0;
                  mem_a    <= maddr_i;
                  mem_wr   <= is_store;
                  mem_dout <= wdata_i[7:0];
               end
            end
            XFER: begin
               if (idx != 2'd0) begin
                  load_buf[{prev_idx, 3'b000} +: 8] <= mem_din;
               end
               if (idx == last_idx) begin
                  mem_wr <= 1'b0;
                  if (is_store) begin
                     state <= DONE;
                     req_o <= 1'b0;
                  end else begin
                     state <= DRAIN;
                  end
               end else begin
                  idx      <= next_idx;
                  mem_a    <= maddr_i + ADDR_W'(next_idx);
                  mem_dout <= wdata_i[{next_idx, 3'b000} +: 8];
               end
            end
            DRAIN: begin
               load_buf[{idx, 3'b000} +: 8] <= mem_din;
               state <= DONE;
               req_o <= 1'b0;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Sign/zero extension of the assembled load bytes
   always_comb begin
      case (alufunct3_i)
         3'b000:  load_ext = {{(DATA_W-8){load_buf[7]}}, load_buf[7:0]};
         3'b001:  load_ext = {{(DATA_W-16){load_buf[15]}}, load_buf[15:0]};
         3'b100:  load_ext = {{(DATA_W-8){1'b0}}, load_buf[7:0]};
         3'b101:  load_ext = {{(DATA_W-16){1'b0}}, load_buf[15:0]};
         default: load_ext = load_buf;
      endcase
   end

   // Stall and mem_wb outputs; everything is held at zero while in reset
   always_comb begin
      stall_o = 1'b0;
      wreg_o  = 1'b0;
      wd_o    = 5'd0;
      wdata_o = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (me_i) begin
                  stall_o = 1'b1;
               end else begin
                  wreg_o  = wreg_i;
                  wd_o    = wd_i;
                  wdata_o = wdata_i;
               end
            end
            WAIT_GNT, XFER, DRAIN: begin
               stall_o = 1'b1;
            end
            DONE: begin
               wreg_o  = wreg_i & ~is_store;
               wd_o    = wd_i;
               wdata_o = (is_store || illegal_size) ? '0 : load_ext;
            end
            default: begin
               stall_o = 1'b0;
            end
         endcase
      end
   end

   assign wreg_f  = wreg_o & ~stall_o;
   assign wd_f    = wd_o;
   assign wdata_f = wdata_o;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: drives random and directed instructions into mem_access,
// emulates the byte-wide memory on the bus and compares every cycle against a
// timeline model derived from the access size, grant delay and memory image.
module tb_mem_access;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0010011;

   typedef struct packed {
      logic [6:0]  aluop;
      logic [2:0]  f3;
      logic        me;
      logic [31:0] maddr;
      logic        wreg;
      logic [4:0]  wd;
      logic [31:0] wdata;
      logic [3:0]  d;
   } instr_t;

   typedef struct packed {
      logic        stall;
      logic        req;
      logic        wr;
      logic        wreg;
      logic        chk_bus;
      logic        chk_dout;
      logic        chk_wd;
      logic        chk_wdata;
      logic [31:0] a;
      logic [7:0]  dout;
      logic [4:0]  wd;
      logic [31:0] wdata;
   } expect_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  aluop_i;
   logic [2:0]  alufunct3_i;
   logic        me_i;
   logic [31:0] maddr_i;
   logic        wreg_i;
   logic [4:0]  wd_i;
   logic [31:0] wdata_i;
   logic        gnt_i;
   logic        req_o;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic        stall_o;
   logic        wreg_o;
   logic [4:0]  wd_o;
   logic [31:0] wdata_o;
   logic        wreg_f;
   logic [4:0]  wd_f;
   logic [31:0] wdata_f;

   int          check_count = 0;
   int          pass_count = 0;
   instr_t      cur;
   int          k = 0;
   int          mode = 2;
   int          serial = 0;
   int          rec_serial = 0;
   logic        pin_k_en = 1'b0;
   int          pin_k = 0;
   logic        pin_w_en = 1'b0;
   logic [31:0] pin_w = 32'd0;

   logic [7:0]  bus_mem [256];
   logic [7:0]  ref_mem [256];
   logic        fill_valid = 1'b0;
   logic        poke_valid = 1'b0;
   logic [7:0]  poke_addr = 8'd0;
   logic [7:0]  poke_data = 8'd0;

   // Free-running clock
   always #5 clk = ~clk;

   mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .alufunct3_i(alufunct3_i),
      .me_i(me_i), .maddr_i(maddr_i), .wreg_i(wreg_i), .wd_i(wd_i),
      .wdata_i(wdata_i), .gnt_i(gnt_i), .req_o(req_o), .mem_a(mem_a),
      .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
      .stall_o(stall_o), .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o),
      .wreg_f(wreg_f), .wd_f(wd_f), .wdata_f(wdata_f)
   );

   function automatic logic [7:0] seed_byte(int i);
      return 8'((i * 37 + 11) ^ (i >> 2));
   endfunction

   function automatic logic [7:0] low8(logic [31:0] a, int b);
      logic [31:0] t;
      t = a + 32'(b);
      return t[7:0];
   endfunction

   function automatic int nbytes(logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic is_store_op(instr_t in);
      return in.aluop == OP_STORE;
   endfunction

   // Cycle (relative to arrival) in which the instruction completes
   function automatic int done_of(instr_t in);
      int n;
      n = nbytes(in.f3);
      if (!in.me) return 0;
      if (n == 0) return 1;
      return is_store_op(in) ? (2 + int'(in.d) + n) : (3 + int'(in.d) + n);
   endfunction

   // Value a load must return, assembled from the reference memory image
   function automatic logic [31:0] load_value(instr_t in);
      logic [31:0] raw;
      raw = 32'd0;
      for (int b = 0; b < nbytes(in.f3); b++) begin
         raw = raw | (32'(ref_mem[low8(in.maddr, b)]) << (8 * b));
      end
      case (in.f3)
         3'b000:  return (raw >= 32'h80)   ? raw - 32'h100   : raw;
         3'b001:  return (raw >= 32'h8000) ? raw - 32'h10000 : raw;
         3'b011:  return 32'd0;
         default: return raw;
      endcase
   endfunction

   // Expected outputs of the stage k cycles after instruction arrival
   function automatic expect_t model(instr_t in, int k_in);
      expect_t e;
      int n;
      int dk;
      int first_bus;
      e = '0;
      n = nbytes(in.f3);
      dk = done_of(in);
      first_bus = 2 + int'(in.d);
      if (!in.me) begin
         e.wreg = in.wreg;
         e.chk_wd = 1'b1;
         e.wd = in.wd;
         e.chk_wdata = 1'b1;
         e.wdata = in.wdata;
      end else begin
         e.stall = (k_in < dk);
         e.req = (n != 0) && (k_in >= 1) && (k_in < dk);
         if (n != 0 && k_in >= first_bus && k_in < first_bus + n) begin
            e.chk_bus = 1'b1;
            e.a = in.maddr + 32'(k_in - first_bus);
            e.wr = is_store_op(in);
            e.chk_dout = is_store_op(in);
            e.dout = 8'(in.wdata >> (8 * (k_in - first_bus)));
         end
         if (k_in == dk) begin
            e.wreg = in.wreg & ~is_store_op(in);
            e.chk_wd = 1'b1;
            e.wd = in.wd;
            e.chk_wdata = !is_store_op(in);
            e.wdata = load_value(in);
         end
      end
      return e;
   endfunction

   function automatic logic gnt_for(instr_t in, int k_in);
      if (in.me && k_in >= 1 && k_in <= int'(in.d)) return 1'b0;
      if (k_in == int'(in.d) + 1) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic instr_t mk(logic [6:0] op, logic [2:0] f3, logic me,
                                 logic [31:0] a, logic wreg, logic [4:0] wd,
                                 logic [31:0] wdata, int d);
      instr_t in;
      in.aluop = op;
      in.f3 = f3;
      in.me = me;
      in.maddr = a;
      in.wreg = wreg;
      in.wd = wd;
      in.wdata = wdata;
      in.d = 4'(d);
      return in;
   endfunction

   // Byte-wide memory on the bus: read data returns one cycle after the address
   always @(posedge clk) begin
      mem_din <= bus_mem[mem_a[7:0]];
      if (fill_valid) begin
         for (int i = 0; i < 256; i++) bus_mem[i] <= seed_byte(i);
      end else if (poke_valid) begin
         bus_mem[poke_addr] <= poke_data;
      end else if (mem_wr) begin
         bus_mem[mem_a[7:0]] <= mem_dout;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      check_count++;
      if (act === exp_v) pass_count++;
      else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d of instr %0d)",
                    name, act, exp_v, k, serial);
   endtask

   // Single compare process: checks DUT outputs every cycle mid-period
   always @(negedge clk) begin
      expect_t e;
      if (mode == 2) begin
         checkOutput("rst_req", 32'(req_o), 32'd0);
         checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
         checkOutput("rst_mem_a", mem_a, 32'd0);
         checkOutput("rst_mem_dout", 32'(mem_dout), 32'd0);
      end
      if (mode == 1 || mode == 2) begin
         checkOutput("rst_stall", 32'(stall_o), 32'd0);
         checkOutput("rst_wreg_o", 32'(wreg_o), 32'd0);
         checkOutput("rst_wd_o", 32'(wd_o), 32'd0);
         checkOutput("rst_wdata_o", wdata_o, 32'd0);
         checkOutput("rst_wreg_f", 32'(wreg_f), 32'd0);
         checkOutput("rst_wd_f", 32'(wd_f), 32'd0);
         checkOutput("rst_wdata_f", wdata_f, 32'd0);
      end
      if (mode == 1) begin
         e = model(cur, k);
         checkOutput("inflight_mem_wr", 32'(mem_wr), 32'(e.wr));
         checkOutput("inflight_mem_a", mem_a, e.a);
      end
      if (mode == 0) begin
         e = model(cur, k);
         checkOutput("stall_o", 32'(stall_o), 32'(e.stall));
         checkOutput("req_o", 32'(req_o), 32'(e.req));
         checkOutput("mem_wr", 32'(mem_wr), 32'(e.wr));
         checkOutput("wreg_o", 32'(wreg_o), 32'(e.wreg));
         checkOutput("wreg_f", 32'(wreg_f), 32'(e.wreg));
         if (e.chk_bus) checkOutput("mem_a", mem_a, e.a);
         if (e.chk_dout) checkOutput("mem_dout", 32'(mem_dout), 32'(e.dout));
         if (e.chk_wd) begin
            checkOutput("wd_o", 32'(wd_o), 32'(e.wd));
            checkOutput("wd_f", 32'(wd_f), 32'(e.wd));
         end
         if (e.chk_wdata) begin
            checkOutput("wdata_o", wdata_o, e.wdata);
            checkOutput("wdata_f", wdata_f, e.wdata);
         end
         if (stall_o == 1'b0 && rec_serial != serial) begin
            rec_serial = serial;
            if (pin_k_en) checkOutput("pin_latency", 32'(k), 32'(pin_k));
            if (pin_w_en) checkOutput("pin_wdata", wdata_o, pin_w);
         end
      end
   end

   task automatic drive(input instr_t in);
      aluop_i = in.aluop;
      alufunct3_i = in.f3;
      me_i = in.me;
      maddr_i = in.maddr;
      wreg_i = in.wreg;
      wd_i = in.wd;
      wdata_i = in.wdata;
   endtask

   // Issue one instruction and hold it until the cycle it completes in
   task automatic applyStimulus(input instr_t in, input logic pk_en, input int pk,
                                input logic pw_en, input logic [31:0] pw);
      int total;
      serial++;
      cur = in;
      k = 0;
      pin_k_en = pk_en;
      pin_k = pk;
      pin_w_en = pw_en;
      pin_w = pw;
      drive(in);
      gnt_i = gnt_for(in, 0);
      if (in.me && is_store_op(in)) begin
         for (int b = 0; b < nbytes(in.f3); b++) ref_mem[low8(in.maddr, b)] = 8'(in.wdata >> (8 * b));
      end
      total = done_of(in);
      for (int c = 0; c <= total; c++) begin
         @(posedge clk);
         #1;
         if (c < total) begin
            k = k + 1;
            gnt_i = gnt_for(in, k);
         end
      end
   endtask

   task automatic pokeByte(input logic [31:0] a, input logic [7:0] v);
      ref_mem[a[7:0]] = v;
      poke_addr = a[7:0];
      poke_data = v;
      poke_valid = 1'b1;
      applyStimulus(mk(OP_ALU, 3'b000, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 0), 1'b0, 0, 1'b0, 32'd0);
      poke_valid = 1'b0;
   endtask

   // Stimulus: reset, directed cases with literal results, random mix, mid-transfer reset
   initial begin
      instr_t in;
      instr_t nop;
      nop = mk(OP_ALU, 3'b000, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 0);
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_byte(i);
      cur = nop;
      drive(nop);
      gnt_i = 1'b0;
      rst = 1'b1;
      mode = 2;
      fill_valid = 1'b1;
      @(posedge clk);
      #1;
      fill_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      mode = 0;

      $display("[TB] directed cases");
      applyStimulus(mk(OP_ALU, 3'b000, 1'b0, 32'd0, 1'b1, 5'd3, 32'h5, 0), 1'b1, 0, 1'b1, 32'h5);
      pokeByte(32'h100, 8'h11);
      pokeByte(32'h101, 8'h22);
      pokeByte(32'h102, 8'h33);
      pokeByte(32'h103, 8'h44);
      applyStimulus(mk(OP_LOAD, 3'b010, 1'b1, 32'h100, 1'b1, 5'd7, 32'd0, 0), 1'b1, 7, 1'b1, 32'h44332211);
      pokeByte(32'h200, 8'h80);
      applyStimulus(mk(OP_LOAD, 3'b000, 1'b1, 32'h200, 1'b1, 5'd8, 32'd0, 0), 1'b1, 4, 1'b1, 32'hFFFFFF80);
      applyStimulus(mk(OP_LOAD, 3'b100, 1'b1, 32'h200, 1'b1, 5'd8, 32'd0, 0), 1'b1, 4, 1'b1, 32'h00000080);
      pokeByte(32'h300, 8'h34);
      pokeByte(32'h301, 8'h92);
      applyStimulus(mk(OP_LOAD, 3'b001, 1'b1, 32'h300, 1'b1, 5'd9, 32'd0, 0), 1'b1, 5, 1'b1, 32'hFFFF9234);
      applyStimulus(mk(OP_LOAD, 3'b101, 1'b1, 32'h300, 1'b1, 5'd9, 32'd0, 0), 1'b1, 5, 1'b1, 32'h00009234);
      applyStimulus(mk(OP_STORE, 3'b001, 1'b1, 32'h400, 1'b1, 5'd4, 32'hDEADBEEF, 0), 1'b1, 4, 1'b0, 32'd0);
      applyStimulus(mk(OP_STORE, 3'b001, 1'b1, 32'h400, 1'b1, 5'd4, 32'hDEADBEEF, 3), 1'b1, 7, 1'b0, 32'd0);
      applyStimulus(mk(OP_LOAD, 3'b101, 1'b1, 32'h400, 1'b1, 5'd2, 32'd0, 0), 1'b1, 5, 1'b1, 32'h0000BEEF);
      applyStimulus(mk(OP_STORE, 3'b010, 1'b1, 32'hFFFFFFFE, 1'b0, 5'd0, 32'h01020304, 0), 1'b1, 6, 1'b0, 32'd0);
      applyStimulus(mk(OP_LOAD, 3'b010, 1'b1, 32'hFFFFFFFE, 1'b1, 5'd1, 32'd0, 1), 1'b1, 8, 1'b1, 32'h01020304);
      applyStimulus(mk(OP_LOAD, 3'b011, 1'b1, 32'h100, 1'b1, 5'd6, 32'd0, 2), 1'b1, 1, 1'b1, 32'd0);

      $display("[TB] random mix");
      for (int n = 0; n < 200; n++) begin
         int r;
         logic [31:0] a;
         logic [2:0] f3;
         r = $urandom_range(0, 9);
         a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
         if (r <= 2) begin
            in = mk(OP_ALU, 3'($urandom), 1'b0, a, 1'($urandom), 5'($urandom), $urandom, 0);
         end else if (r <= 5) begin
            case ($urandom_range(0, 4))
               0:       f3 = 3'b000;
               1:       f3 = 3'b001;
               2:       f3 = 3'b010;
               3:       f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
            in = mk(OP_LOAD, f3, 1'b1, a, 1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3));
         end else if (r <= 8) begin
            f3 = 3'($urandom_range(0, 2));
            in = mk(OP_STORE, f3, 1'b1, a, 1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3));
         end else begin
            in = mk(($urandom_range(0, 1) == 0) ? OP_LOAD : OP_STORE, 3'b011, 1'b1, a,
                    1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3));
         end
         applyStimulus(in, 1'b0, 0, 1'b0, 32'd0);
      end

      $display("[TB] reset during a word store");
      in = mk(OP_STORE, 3'b010, 1'b1, 32'h500, 1'b0, 5'd9, 32'hA1B2C3D4, 0);
      serial++;
      cur = in;
      k = 0;
      pin_k_en = 1'b0;
      pin_w_en = 1'b0;
      drive(in);
      gnt_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         k = k + 1;
      end
      rst = 1'b1;
      mode = 1;
      @(posedge clk);
      #1;
      mode = 2;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ref_mem[8'h00] = 8'hD4;
      ref_mem[8'h01] = 8'hC3;
      ref_mem[8'h02] = 8'hB2;
      mode = 0;
      for (int c = 0; c < 4; c++) applyStimulus(nop, 1'b0, 0, 1'b0, 32'd0);
      applyStimulus(mk(OP_LOAD, 3'b001, 1'b1, 32'h501, 1'b1, 5'd5, 32'd0, 0), 1'b1, 5, 1'b1, 32'hFFFFB2C3);
      applyStimulus(mk(OP_LOAD, 3'b010, 1'b1, 32'h500, 1'b1, 5'd5, 32'd0, 0), 1'b1, 7, 1'b0, 32'd0);

      mode = 3;
      @(posedge clk);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
